// File: rtl/serial_tx4_if.sv
// serial_tx4_if -- handshake and serial-line bundle for serial_tx4.
// master: the side that requests frames (drives EN, load, D).
// slave : the transmitter itself.
// Handshake: a word on D is taken on any rising edge where ready=1 and
// load=1 (EN does not matter); ready stays low for the whole frame, so
// load while busy has no effect. state_dbg mirrors the FSM state register.
interface serial_tx4_if #(
  parameter int DATA_W = 4
);
  logic              EN;
  logic              load;
  logic [DATA_W-1:0] D;
  logic              ready;
  logic              TX;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;

  modport master (
    output EN, load, D,
    input  ready, TX, busy, done, state_dbg
  );

  modport slave (
    input  EN, load, D,
    output ready, TX, busy, done, state_dbg
  );
endinterface

// File: rtl/serial_tx4.sv
// serial_tx4 -- serial frame transmitter, the sending end of the
// serial-in/parallel-out D-register receiver.
// Frame: start(0), D LSB first, [even parity], stop(1). The frame only
// advances on edges where EN=1; loading ignores EN.
// Optional feature: define SERIAL_TX4_PARITY_EN to add the PARITY state,
// which sends the XOR of the captured word between the last data bit and stop.
// Reset: synchronous, active-low.
module serial_tx4 #(
  parameter int DATA_W = 4
) (
  input logic          clock,
  input logic          reset,
  serial_tx4_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERIAL_TX4_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              tx_q,    tx_d;
  logic              done_q,  done_d;
`ifdef SERIAL_TX4_PARITY_EN
  logic              par_q,   par_d;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef SERIAL_TX4_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          shift_d = bus.D;
`ifdef SERIAL_TX4_PARITY_EN
          par_d   = ^bus.D;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (bus.EN) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.EN) begin
          if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX4_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef SERIAL_TX4_PARITY_EN
      S_PARITY: begin
        if (bus.EN) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bus.EN) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // TX is registered, so it is derived from where the FSM is going; a
    // frozen FSM (EN=0) therefore re-selects the same bit and TX holds.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef SERIAL_TX4_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef SERIAL_TX4_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef SERIAL_TX4_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.TX        = tx_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_serial_tx4.sv
// tb_serial_tx4 -- directed bench for serial_tx4 (DATA_W=4).
// Expected TX sequences are hand-computed frames; parity variants are
// selected with SERIAL_TX4_PARITY_EN, matching the design build.
module tb_serial_tx4;

  logic clock;
  logic reset;

  serial_tx4_if #(.DATA_W(4)) bus ();

  serial_tx4 #(.DATA_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec;
  int n_err;
  int done_seen;
  logic [0:0] exp_q[$];
  logic [0:0] obs_q[$];

  // advance one edge; outputs are observed 1 time unit after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // record TX for every busy cycle until the line returns to idle (bounded)
  task automatic collect(input bit toggle_en);
    obs_q.delete();
    done_seen = 0;
    for (int c = 0; c < 64; c++) begin
      if (!bus.busy) break;
      obs_q.push_back(bus.TX);
      if (bus.done) done_seen++;
      if (toggle_en) bus.EN = ~bus.EN;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.EN = 1'b1; bus.load = 1'b1; bus.D = 4'b1010;
    step();
    reset = 1'b1; bus.load = 1'b0; bus.EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.TX !== 1'b1 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got TX=%b ready=%b busy=%b done=%b want 1 1 0 0",
                 i, bus.TX, bus.ready, bus.busy, bus.done);
      end
      step();
    end
  endtask

  task automatic test_basic();
    bus.EN = 1'b1; bus.load = 1'b1; bus.D = 4'b0101;
    step();
    bus.load = 1'b0; bus.D = 4'b0000;
    n_vec++;
    if (bus.TX !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_first: got TX=%b busy=%b want 0 1", bus.TX, bus.busy);
    end
`ifdef SERIAL_TX4_PARITY_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    collect(1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL basic_len: got %0d busy cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_bit[%0d]: got %b want %b", i, (i < obs_q.size()) ? obs_q[i] : 1'bx, exp_q[i]);
      end
    end
    n_vec++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b1 || done_seen != 0) begin
      n_err++;
      $display("FAIL basic_done: got done=%b ready=%b early=%0d want 1 1 0", bus.done, bus.ready, done_seen);
    end
    step();
    n_vec++;
    if (bus.done !== 1'b0 || bus.TX !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done_clear: got done=%b TX=%b want 0 1", bus.done, bus.TX);
    end
  endtask

  task automatic test_en_toggle();
    bus.EN = 1'b1; bus.load = 1'b1; bus.D = 4'b0111;
    step();
    bus.load = 1'b0;
`ifdef SERIAL_TX4_PARITY_EN
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    collect(1'b1);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL toggle_len: got %0d busy cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL toggle_bit[%0d]: got %b want %b", i, (i < obs_q.size()) ? obs_q[i] : 1'bx, exp_q[i]);
      end
    end
    n_vec++;
    if (bus.done !== 1'b1 || done_seen != 0) begin
      n_err++;
      $display("FAIL toggle_done: got done=%b early=%0d want 1 0", bus.done, done_seen);
    end
    bus.EN = 1'b1;
    step();
  endtask

  task automatic test_freeze();
    bus.EN = 1'b1; bus.load = 1'b1; bus.D = 4'b1010;
    step();                 // START
    bus.load = 1'b0;
    step();                 // bit0 = 0
    step();                 // bit1 = 1
    bus.EN = 1'b0; bus.load = 1'b1; bus.D = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (bus.TX !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL freeze_hold[%0d]: got TX=%b busy=%b done=%b want 1 1 0", i, bus.TX, bus.busy, bus.done);
      end
    end
    bus.EN = 1'b1; bus.load = 1'b0;
    step();
    n_vec++;
    if (bus.TX !== 1'b0) begin
      n_err++;
      $display("FAIL freeze_bit2: got %b want 0", bus.TX);
    end
    step();
    n_vec++;
    if (bus.TX !== 1'b1) begin
      n_err++;
      $display("FAIL freeze_bit3: got %b want 1", bus.TX);
    end
`ifdef SERIAL_TX4_PARITY_EN
    exp_q = '{1'b0, 1'b1};
`else
    exp_q = '{1'b1};
`endif
    step();
    collect(1'b0);
    n_vec++;
    if (obs_q != exp_q || bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL freeze_tail: got %0d cycles done=%b want %0d cycles done=1", obs_q.size(), bus.done, exp_q.size());
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.EN = 1'b1; bus.load = 1'b1; bus.D = 4'b0011;
    step();
    bus.D = 4'b1111;        // load stays high through the frame
`ifdef SERIAL_TX4_PARITY_EN
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    collect(1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_len0: got %0d busy cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_f0_bit[%0d]: got %b want %b", i, (i < obs_q.size()) ? obs_q[i] : 1'bx, exp_q[i]);
      end
    end
    n_vec++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done0: got done=%b ready=%b want 1 1", bus.done, bus.ready);
    end
    step();
    bus.load = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.TX !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_start1: got busy=%b TX=%b done=%b want 1 0 0", bus.busy, bus.TX, bus.done);
    end
`ifdef SERIAL_TX4_PARITY_EN
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    collect(1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_len1: got %0d busy cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_f1_bit[%0d]: got %b want %b", i, (i < obs_q.size()) ? obs_q[i] : 1'bx, exp_q[i]);
      end
    end
    step();
  endtask

  task automatic test_mid_reset();
    bus.EN = 1'b1; bus.load = 1'b1; bus.D = 4'b0101;
    step();                 // START
    bus.load = 1'b0;
    step();                 // bit0
    step();                 // bit1
    step();                 // bit2
    n_vec++;
    if (bus.TX !== 1'b1) begin
      n_err++;
      $display("FAIL mid_bit2: got %b want 1", bus.TX);
    end
    reset = 1'b0; bus.load = 1'b1; bus.D = 4'b1111;
    step();
    reset = 1'b1; bus.load = 1'b0;
    n_vec++;
    if (bus.TX !== 1'b1 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_abort: got TX=%b ready=%b busy=%b done=%b want 1 1 0 0",
               bus.TX, bus.ready, bus.busy, bus.done);
    end
    step();
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_no_done: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    bus.load = 1'b1; bus.D = 4'b1000;
    step();
    bus.load = 1'b0;
`ifdef SERIAL_TX4_PARITY_EN
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    collect(1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL mid_len: got %0d busy cycles want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL mid_bit[%0d]: got %b want %b", i, (i < obs_q.size()) ? obs_q[i] : 1'bx, exp_q[i]);
      end
    end
    n_vec++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL mid_done: got %b want 1", bus.done);
    end
    step();
  endtask

  initial begin
    n_vec = 0; n_err = 0; done_seen = 0;
    reset = 1'b0; bus.EN = 1'b0; bus.load = 1'b0; bus.D = '0;
    test_reset();
    test_basic();
    test_en_toggle();
    test_freeze();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx4.md
SERIAL_TX4 -- requirements
Module: serial_tx4

Interface
REQ-001 Parameter DATA_W, default 4, is the data word width in bits; legal range 1..8.
REQ-002 clock  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous and active-low (0 = reset asserted at the rising clock edge).
REQ-004 EN  input  1  bit-tick enable; the frame advances one bit only on edges where EN=1.
REQ-005 load  input  1  request to send; qualified by ready.
REQ-006 D  input  DATA_W  parallel word to transmit.
REQ-007 ready  output  1  high when a load is accepted on the next edge.
REQ-008 TX  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 done  output  1  one-cycle pulse after the stop bit completes.

Function
REQ-011 The block SHALL be the transmit end of the team's serial-in/parallel-out D-register receiver: frame = start(0), D LSB first, [parity], stop(1).
REQ-012 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP; encoding is free.
REQ-013 ready SHALL be 1 only in IDLE; busy SHALL be the complement of ready.
REQ-014 A load SHALL be accepted on any edge with ready=1 and load=1, independent of EN; D is captured into an internal shift register on that edge, and the FSM moves IDLE->START.
REQ-015 D SHALL be ignored when not accepted; changes to D after acceptance SHALL NOT affect the frame.
REQ-016 TX SHALL be a registered output: 1 in IDLE and STOP, 0 in START, current LSB of shift register in DATA, parity bit in PARITY.
REQ-017 Each of START, each DATA bit, PARITY and STOP SHALL last until an edge with EN=1; on that edge the FSM advances (START->DATA, DATA->DATA with shift right and bit counter +1, last DATA bit->PARITY or STOP, PARITY->STOP, STOP->IDLE).
REQ-018 The bit counter SHALL be wide enough for DATA_W-1 and SHALL reset to 0 on entering DATA.
REQ-019 With EN held 1, a frame SHALL occupy exactly DATA_W+2 cycles of busy (DATA_W+3 with parity); TX=0 on the first cycle after acceptance.
REQ-020 done SHALL be 1 for exactly the one cycle following the STOP->IDLE edge, and 0 otherwise; ready is 1 in that same cycle.
REQ-021 load asserted while busy SHALL be ignored (no queueing, no effect on the frame).
REQ-022 EN=0 for any number of cycles SHALL freeze state, counter, shift register and TX.

Reset
REQ-023 On an edge with reset=0: state=IDLE, TX=1, ready=1, busy=0, done=0, shift register=0, counter=0, regardless of load/EN.
REQ-024 reset=0 mid-frame SHALL abort the frame on that edge; no done pulse is generated.
REQ-025 reset SHALL take priority over load on the same edge.

Configuration
REQ-026 Macro SERIAL_TX4_PARITY_EN: when defined, the PARITY state SHALL exist and transmit even parity (XOR of the captured D bits) between the last data bit and stop.
REQ-027 When SERIAL_TX4_PARITY_EN is undefined, the PARITY state and parity logic SHALL be absent and the last DATA bit SHALL go directly to STOP.

Verification
REQ-028 reset=0 one edge, then reset=1, load=0 -> TX=1, ready=1, busy=0, done=0 held.
REQ-029 EN=1 constant, load=1 with D=4'b0101 for one cycle -> TX sequence 0,1,0,1,0,1 (start, LSB first, stop), done pulse once, total busy 6 cycles; with macro, sequence 0,1,0,1,0,0,1 and busy 7 cycles.
REQ-030 D=4'b0111, EN toggling 1,0,1,0... -> each bit held 2 cycles, same bit order; with macro parity bit=1.
REQ-031 load=1 held with D changed to 4'b1111 during frame of 4'b0011 -> frame carries 0011 only; next frame 1111 starts the cycle after done.
REQ-032 reset=0 during third data bit -> next cycle TX=1, ready=1, done=0; following load of 4'b1000 transmits cleanly.
